multicycle_control_unit: RTL and testbench
==========================================

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter OPCODE_W, default 6, opcode field width; HALT opcode SHALL be all ones (6'b111111 at default).
REQ-002 Parameter ALUOP_W, default 3, ALU operation code width.
REQ-003 Parameter CNT_W, default 32, retired-instruction counter width.
REQ-004 clock  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 opcode  in  OPCODE_W  opcode field of the instruction register; captured in DECODE.
REQ-007 in_valid  in  1  external input data available.
REQ-008 out_ready  in  1  external sink accepts output data.
REQ-009 resume  in  1  one-cycle pulse releasing HALTED.
REQ-010 pc_inc, ir_write  out  1 each  PC+1 and instruction-register load strobes.
REQ-011 register_dst, jump, mem_to_reg  out  2 each  same encodings as the single-cycle control unit; mem_to_reg 2'b11 selects input port.
REQ-012 branch, alu_src, reg_write, mem_write, mem_read  out  1 each  datapath controls.
REQ-013 alu_op  out  ALUOP_W  ALU operation.
REQ-014 halt, input_flag, output_flag  out  1 each  status/handshake flags.
REQ-015 instr_count  out  CNT_W  retired-instruction count.

Function
REQ-016 States SHALL be FETCH, DECODE, EXECUTE, MEM, WRITEBACK, WAIT_IN, WAIT_OUT, HALTED.
REQ-017 Opcodes: R=0, lw=1, sw=2, addi=3, subi=4, beq=5, j=9, jr=10, jal=11, in=12, out=13, halt=all ones; any other value SHALL execute as NOP (EXECUTE -> FETCH, no strobes).
REQ-018 FETCH: ir_write=1, pc_inc=1 for exactly one cycle -> DECODE.
REQ-019 DECODE: opcode latched into internal register; no strobes -> EXECUTE; outputs in later states SHALL derive from the latched opcode only.
REQ-020 EXECUTE: alu_src, alu_op, branch, jump, register_dst driven per opcode (R: alu_op=3'b100, register_dst=1; addi/lw/sw: alu_op=0, alu_src=1; subi: alu_op=3'b001, alu_src=1; beq: alu_op=3'b011, branch=1; j/jal: jump=2'b01; jr: jump=2'b10).
REQ-021 EXECUTE transitions: R/addi/subi/jal -> WRITEBACK; lw/sw -> MEM; beq/j/jr/NOP -> FETCH; in -> WAIT_IN; out -> WAIT_OUT; halt -> HALTED.
REQ-022 MEM: lw asserts mem_read=1 -> WRITEBACK; sw asserts mem_write=1 -> FETCH; alu_src/alu_op held from EXECUTE.
REQ-023 WRITEBACK: reg_write=1 one cycle; mem_to_reg=1 for lw, 2'b10 and register_dst=2'b10 for jal, 0 otherwise -> FETCH.
REQ-024 WAIT_IN: input_flag=1 every cycle; on in_valid=1: reg_write=1, mem_to_reg=2'b11 that cycle -> FETCH; otherwise stay.
REQ-025 WAIT_OUT: output_flag=1 every cycle; on out_ready=1 -> FETCH; otherwise stay.
REQ-026 HALTED: halt=1 every cycle; on resume=1 -> FETCH; otherwise stay; in_valid/out_ready ignored.
REQ-027 Any output not listed for a state SHALL be 0 in that state.
REQ-028 Latency: NOP/beq/j/jr 3 cycles, sw 4, R/addi/subi/jal 4, lw 5, in/out 4 + wait cycles.
REQ-029 An instruction retires on any transition into FETCH from EXECUTE, MEM, WRITEBACK, WAIT_IN, WAIT_OUT (not from HALTED, not after reset).

Reset
REQ-030 reset=0 at a clock edge SHALL force state FETCH, latched opcode 0, instr_count 0, regardless of current state (including mid-wait and HALTED).
REQ-031 While reset=0 all control outputs SHALL be 0; first FETCH strobes appear in the first cycle after reset=1.

Configuration
REQ-032 Macro CU_PERF_COUNT_EN defined: instr_count increments by 1 per retirement (REQ-029), wrapping modulo 2^CNT_W.
REQ-033 Macro CU_PERF_COUNT_EN undefined: instr_count port present and constantly 0; no counter logic.

Verification
REQ-034 Reset, then opcode=0 -> FETCH, DECODE, EXECUTE(alu_op=3'b100, register_dst=1), WRITEBACK(reg_write=1), FETCH on cycle 5.
REQ-035 opcode=1 -> MEM cycle mem_read=1, then WRITEBACK reg_write=1, mem_to_reg=1; 5 cycles total.
REQ-036 opcode=12, in_valid low 3 cycles then high -> input_flag=1 for 4 cycles, reg_write=1 and mem_to_reg=2'b11 only on cycle in_valid=1.
REQ-037 opcode=6'b111111 -> halt=1 held 10 cycles with out_ready/in_valid toggling; resume pulse -> FETCH next cycle, halt=0.
REQ-038 reset=0 asserted while in WAIT_OUT -> next cycle all outputs 0, instr_count=0; after release FETCH strobes resume.
REQ-039 CU_PERF_COUNT_EN, CNT_W=4, 17 NOPs (opcode 6'b010000) -> instr_count=1 after wrap; undefined -> instr_count=0 throughout.

Source files
------------

// File: rtl/multicycle_control_unit_if.sv
// ============================================================================
//  Module      : multicycle_control_unit_if
//  Description : Instruction/handshake inputs and datapath control outputs
//                shared between the multicycle control unit and its datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface multicycle_control_unit_if #(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 3,
  parameter int CNT_W    = 32
);
  logic [OPCODE_W-1:0] opcode;
  logic                in_valid;
  logic                out_ready;
  logic                resume;

  logic                pc_inc;
  logic                ir_write;
  logic [1:0]          register_dst;
  logic [1:0]          jump;
  logic [1:0]          mem_to_reg;
  logic                branch;
  logic                alu_src;
  logic                reg_write;
  logic                mem_write;
  logic                mem_read;
  logic [ALUOP_W-1:0]  alu_op;
  logic                halt;
  logic                input_flag;
  logic                output_flag;
  logic [CNT_W-1:0]    instr_count;

  // Datapath side: supplies the instruction and handshakes, consumes controls
  modport master (
    output opcode, in_valid, out_ready, resume,
    input  pc_inc, ir_write, register_dst, jump, mem_to_reg, branch,
           alu_src, reg_write, mem_write, mem_read, alu_op, halt,
           input_flag, output_flag, instr_count
  );

  // Control unit side
  modport slave (
    input  opcode, in_valid, out_ready, resume,
    output pc_inc, ir_write, register_dst, jump, mem_to_reg, branch,
           alu_src, reg_write, mem_write, mem_read, alu_op, halt,
           input_flag, output_flag, instr_count
  );
endinterface

`default_nettype wire

// File: rtl/multicycle_control_unit.sv
// ============================================================================
//  Module      : multicycle_control_unit
//  Description : Multicycle CPU control FSM (fetch/decode/execute/mem/wb plus
//                I/O wait and halt states). Optional retired-instruction
//                counter enabled by macro CU_PERF_COUNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control_unit #(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 3,
  parameter int CNT_W    = 32
) (
  input  wire logic                  clock,
  input  wire logic                  reset,
  multicycle_control_unit_if.slave   bus
);

  localparam logic [OPCODE_W-1:0] c_OP_R    = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] c_OP_LW   = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] c_OP_SW   = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] c_OP_ADDI = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] c_OP_SUBI = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] c_OP_BEQ  = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] c_OP_J    = OPCODE_W'(9);
  localparam logic [OPCODE_W-1:0] c_OP_JR   = OPCODE_W'(10);
  localparam logic [OPCODE_W-1:0] c_OP_JAL  = OPCODE_W'(11);
  localparam logic [OPCODE_W-1:0] c_OP_IN   = OPCODE_W'(12);
  localparam logic [OPCODE_W-1:0] c_OP_OUT  = OPCODE_W'(13);
  localparam logic [OPCODE_W-1:0] c_OP_HALT = {OPCODE_W{1'b1}};

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEM       = 3'd3,
    WRITEBACK = 3'd4,
    WAIT_IN   = 3'd5,
    WAIT_OUT  = 3'd6,
    HALTED    = 3'd7
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [OPCODE_W-1:0] r_opcode;

  logic               w_pc_inc;
  logic               w_ir_write;
  logic [1:0]         w_register_dst;
  logic [1:0]         w_jump;
  logic [1:0]         w_mem_to_reg;
  logic               w_branch;
  logic               w_alu_src;
  logic               w_reg_write;
  logic               w_mem_write;
  logic               w_mem_read;
  logic [ALUOP_W-1:0] w_alu_op;
  logic               w_halt;
  logic               w_input_flag;
  logic               w_output_flag;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state  <= FETCH;
      r_opcode <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == DECODE) begin
        r_opcode <= bus.opcode;
      end
    end
  end

  always_comb begin
    w_next         = r_state;
    w_pc_inc       = 1'b0;
    w_ir_write     = 1'b0;
    w_register_dst = 2'b00;
    w_jump         = 2'b00;
    w_mem_to_reg   = 2'b00;
    w_branch       = 1'b0;
    w_alu_src      = 1'b0;
    w_reg_write    = 1'b0;
    w_mem_write    = 1'b0;
    w_mem_read     = 1'b0;
    w_alu_op       = '0;
    w_halt         = 1'b0;
    w_input_flag   = 1'b0;
    w_output_flag  = 1'b0;

    case (r_state)
      FETCH: begin
        w_ir_write = 1'b1;
        w_pc_inc   = 1'b1;
        w_next     = DECODE;
      end

      DECODE: begin
        w_next = EXECUTE;
      end

      EXECUTE: begin
        // Unlisted opcodes fall through to default and retire as a NOP
        case (r_opcode)
          c_OP_R: begin
            w_alu_op       = ALUOP_W'(3'b100);
            w_register_dst = 2'b01;
            w_next         = WRITEBACK;
          end
          c_OP_LW, c_OP_SW: begin
            w_alu_src = 1'b1;
            w_next    = MEM;
          end
          c_OP_ADDI: begin
            w_alu_src = 1'b1;
            w_next    = WRITEBACK;
          end
          c_OP_SUBI: begin
            w_alu_src = 1'b1;
            w_alu_op  = ALUOP_W'(3'b001);
            w_next    = WRITEBACK;
          end
          c_OP_BEQ: begin
            w_alu_op = ALUOP_W'(3'b011);
            w_branch = 1'b1;
            w_next   = FETCH;
          end
          c_OP_J, c_OP_JR: begin
            w_jump = (r_opcode == c_OP_JR) ? 2'b10 : 2'b01;
            w_next = FETCH;
          end
          c_OP_JAL: begin
            w_jump = 2'b01;
            w_next = WRITEBACK;
          end
          c_OP_IN:   w_next = WAIT_IN;
          c_OP_OUT:  w_next = WAIT_OUT;
          c_OP_HALT: w_next = HALTED;
          default:   w_next = FETCH;
        endcase
      end

      MEM: begin
        // Address computation stays on the ALU while memory is accessed
        w_alu_src = 1'b1;
        if (r_opcode == c_OP_LW) begin
          w_mem_read = 1'b1;
          w_next     = WRITEBACK;
        end else begin
          w_mem_write = 1'b1;
          w_next      = FETCH;
        end
      end

      WRITEBACK: begin
        w_reg_write = 1'b1;
        if (r_opcode == c_OP_LW) begin
          w_mem_to_reg = 2'b01;
        end else if (r_opcode == c_OP_JAL) begin
          w_mem_to_reg   = 2'b10;
          w_register_dst = 2'b10;
        end
        w_next = FETCH;
      end

      WAIT_IN: begin
        w_input_flag = 1'b1;
        if (bus.in_valid) begin
          w_reg_write  = 1'b1;
          w_mem_to_reg = 2'b11;
          w_next       = FETCH;
        end
      end

      WAIT_OUT: begin
        w_output_flag = 1'b1;
        if (bus.out_ready) begin
          w_next = FETCH;
        end
      end

      HALTED: begin
        w_halt = 1'b1;
        if (bus.resume) begin
          w_next = FETCH;
        end
      end

      default: w_next = FETCH;
    endcase

    // Reset is synchronous, so the outputs must be masked while it is held
    if (!reset) begin
      w_pc_inc       = 1'b0;
      w_ir_write     = 1'b0;
      w_register_dst = 2'b00;
      w_jump         = 2'b00;
      w_mem_to_reg   = 2'b00;
      w_branch       = 1'b0;
      w_alu_src      = 1'b0;
      w_reg_write    = 1'b0;
      w_mem_write    = 1'b0;
      w_mem_read     = 1'b0;
      w_alu_op       = '0;
      w_halt         = 1'b0;
      w_input_flag   = 1'b0;
      w_output_flag  = 1'b0;
    end
  end

  assign bus.pc_inc       = w_pc_inc;
  assign bus.ir_write     = w_ir_write;
  assign bus.register_dst = w_register_dst;
  assign bus.jump         = w_jump;
  assign bus.mem_to_reg   = w_mem_to_reg;
  assign bus.branch       = w_branch;
  assign bus.alu_src      = w_alu_src;
  assign bus.reg_write    = w_reg_write;
  assign bus.mem_write    = w_mem_write;
  assign bus.mem_read     = w_mem_read;
  assign bus.alu_op       = w_alu_op;
  assign bus.halt         = w_halt;
  assign bus.input_flag   = w_input_flag;
  assign bus.output_flag  = w_output_flag;

`ifdef CU_PERF_COUNT_EN
  logic             w_retire;
  logic [CNT_W-1:0] r_count;

  // Leaving HALTED does not retire anything; FETCH never loops to itself
  assign w_retire = (w_next == FETCH) && (r_state != FETCH) && (r_state != HALTED);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_count <= '0;
    end else if (w_retire) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign bus.instr_count = r_count;
`else
  assign bus.instr_count = {CNT_W{1'b0}};
`endif

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
// ============================================================================
//  Module      : tb_multicycle_control_unit
//  Description : Directed self-checking bench for multicycle_control_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control_unit;

  localparam int CNT_W = 4;

  logic clock;
  logic reset;
  int   checks;
  int   failures;
  logic [CNT_W-1:0] exp_cnt;

  multicycle_control_unit_if #(.OPCODE_W(6), .ALUOP_W(3), .CNT_W(CNT_W)) bus ();

  multicycle_control_unit #(.OPCODE_W(6), .ALUOP_W(3), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // {pc_inc, ir_write, register_dst, jump, mem_to_reg, branch, alu_src,
  //  reg_write, mem_write, mem_read, alu_op, halt, input_flag, output_flag}
  logic [18:0] ctl;
  assign ctl = {bus.pc_inc, bus.ir_write, bus.register_dst, bus.jump, bus.mem_to_reg,
                bus.branch, bus.alu_src, bus.reg_write, bus.mem_write, bus.mem_read,
                bus.alu_op, bus.halt, bus.input_flag, bus.output_flag};

  function automatic logic [18:0] cv(input logic pc, input logic ir, input logic [1:0] rd,
                                     input logic [1:0] jmp, input logic [1:0] m2r,
                                     input logic br, input logic as, input logic rw,
                                     input logic mw, input logic mr, input logic [2:0] aop,
                                     input logic h, input logic inf, input logic outf);
    return {pc, ir, rd, jmp, m2r, br, as, rw, mw, mr, aop, h, inf, outf};
  endfunction

  function automatic logic [CNT_W-1:0] cnt_exp(input logic [CNT_W-1:0] model);
`ifdef CU_PERF_COUNT_EN
    return model;
`else
    return (model & '0);
`endif
  endfunction

  logic [18:0] F, Z;
  initial begin
    F = cv(1,1,2'b00,2'b00,2'b00,0,0,0,0,0,3'b000,0,0,0);
    Z = '0;
  end

  task automatic test_reset();
    reset = 1'b0;
    bus.opcode = 6'd0; bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.resume = 1'b0;
    @(posedge clock); #1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (ctl !== Z || bus.instr_count !== '0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d ctl=%h cnt=%0d exp ctl=%h cnt=0", c, ctl, bus.instr_count, Z);
      end
      @(posedge clock); #1;
    end
    reset = 1'b1;
    exp_cnt = '0;
    #1;
    checks++;
    if (ctl !== F) begin
      failures++;
      $display("FAIL reset_release_fetch ctl=%h exp=%h", ctl, F);
    end
  endtask

  task automatic test_opcodes();
    logic [5:0]  ops  [10];
    int          lens [10];
    logic [18:0] ev   [10][5];
    logic [18:0] rw, as;
    rw = cv(0,0,2'b00,2'b00,2'b00,0,0,1,0,0,3'b000,0,0,0);
    as = cv(0,0,2'b00,2'b00,2'b00,0,1,0,0,0,3'b000,0,0,0);
    for (int i = 0; i < 10; i++) for (int c = 0; c < 5; c++) ev[i][c] = Z;
    ops[0] = 6'd0;  lens[0] = 4;
    ev[0][2] = cv(0,0,2'b01,2'b00,2'b00,0,0,0,0,0,3'b100,0,0,0); ev[0][3] = rw;
    ops[1] = 6'd1;  lens[1] = 5;
    ev[1][2] = as; ev[1][3] = cv(0,0,2'b00,2'b00,2'b00,0,1,0,0,1,3'b000,0,0,0);
    ev[1][4] = cv(0,0,2'b00,2'b00,2'b01,0,0,1,0,0,3'b000,0,0,0);
    ops[2] = 6'd2;  lens[2] = 4;
    ev[2][2] = as; ev[2][3] = cv(0,0,2'b00,2'b00,2'b00,0,1,0,1,0,3'b000,0,0,0);
    ops[3] = 6'd3;  lens[3] = 4; ev[3][2] = as; ev[3][3] = rw;
    ops[4] = 6'd4;  lens[4] = 4;
    ev[4][2] = cv(0,0,2'b00,2'b00,2'b00,0,1,0,0,0,3'b001,0,0,0); ev[4][3] = rw;
    ops[5] = 6'd5;  lens[5] = 3;
    ev[5][2] = cv(0,0,2'b00,2'b00,2'b00,1,0,0,0,0,3'b011,0,0,0);
    ops[6] = 6'd9;  lens[6] = 3; ev[6][2] = cv(0,0,2'b00,2'b01,2'b00,0,0,0,0,0,3'b000,0,0,0);
    ops[7] = 6'd10; lens[7] = 3; ev[7][2] = cv(0,0,2'b00,2'b10,2'b00,0,0,0,0,0,3'b000,0,0,0);
    ops[8] = 6'd11; lens[8] = 4;
    ev[8][2] = cv(0,0,2'b00,2'b01,2'b00,0,0,0,0,0,3'b000,0,0,0);
    ev[8][3] = cv(0,0,2'b10,2'b00,2'b10,0,0,1,0,0,3'b000,0,0,0);
    ops[9] = 6'd6;  lens[9] = 3;
    for (int i = 0; i < 10; i++) begin
      ev[i][0] = F;
      for (int c = 0; c < lens[i]; c++) begin
        bus.opcode = ops[i];
        #1;
        checks++;
        if (ctl !== ev[i][c]) begin
          failures++;
          $display("FAIL opcode_seq op=%0d cyc=%0d ctl=%h exp=%h", ops[i], c, ctl, ev[i][c]);
        end
        if (c == 0) begin
          checks++;
          if (bus.instr_count !== cnt_exp(exp_cnt)) begin
            failures++;
            $display("FAIL opcode_count op=%0d cnt=%0d exp=%0d", ops[i], bus.instr_count, cnt_exp(exp_cnt));
          end
        end
        @(posedge clock); #1;
      end
      exp_cnt++;
    end
  endtask

  task automatic test_input();
    logic [18:0] e;
    bus.opcode = 6'd12;
    for (int c = 0; c < 7; c++) begin
      bus.in_valid = (c == 6);
      if (c == 0)      e = F;
      else if (c < 3)  e = Z;
      else if (c < 6)  e = cv(0,0,2'b00,2'b00,2'b00,0,0,0,0,0,3'b000,0,1,0);
      else             e = cv(0,0,2'b00,2'b00,2'b11,0,0,1,0,0,3'b000,0,1,0);
      #1;
      checks++;
      if (ctl !== e) begin
        failures++;
        $display("FAIL input_wait cyc=%0d ctl=%h exp=%h", c, ctl, e);
      end
      @(posedge clock); #1;
    end
    bus.in_valid = 1'b0;
    exp_cnt++;
    #1;
    checks++;
    if (ctl !== F || bus.instr_count !== cnt_exp(exp_cnt)) begin
      failures++;
      $display("FAIL input_retire ctl=%h cnt=%0d exp ctl=%h cnt=%0d", ctl, bus.instr_count, F, cnt_exp(exp_cnt));
    end
  endtask

  task automatic test_output();
    logic [18:0] e;
    bus.opcode = 6'd13;
    for (int c = 0; c < 6; c++) begin
      bus.out_ready = (c == 5);
      bus.in_valid  = (c == 4);
      if (c == 0)     e = F;
      else if (c < 3) e = Z;
      else            e = cv(0,0,2'b00,2'b00,2'b00,0,0,0,0,0,3'b000,0,0,1);
      #1;
      checks++;
      if (ctl !== e) begin
        failures++;
        $display("FAIL output_wait cyc=%0d ctl=%h exp=%h", c, ctl, e);
      end
      @(posedge clock); #1;
    end
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    exp_cnt++;
  endtask

  task automatic test_halt();
    logic [18:0] h;
    h = cv(0,0,2'b00,2'b00,2'b00,0,0,0,0,0,3'b000,1,0,0);
    bus.opcode = 6'b111111;
    @(posedge clock); #1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    for (int c = 0; c < 11; c++) begin
      bus.in_valid  = c[0];
      bus.out_ready = ~c[0];
      bus.resume    = (c == 10);
      #1;
      checks++;
      if (ctl !== h) begin
        failures++;
        $display("FAIL halt_hold cyc=%0d ctl=%h exp=%h", c, ctl, h);
      end
      @(posedge clock); #1;
    end
    bus.resume = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    #1;
    checks++;
    if (ctl !== F || bus.instr_count !== cnt_exp(exp_cnt)) begin
      failures++;
      $display("FAIL halt_resume ctl=%h cnt=%0d exp ctl=%h cnt=%0d", ctl, bus.instr_count, F, cnt_exp(exp_cnt));
    end
  endtask

  task automatic test_reset_in_wait();
    bus.opcode = 6'd13;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clock); #1;
    end
    #1;
    checks++;
    if (bus.output_flag !== 1'b1) begin
      failures++;
      $display("FAIL wait_out_before_reset output_flag=%b exp=1", bus.output_flag);
    end
    reset = 1'b0;
    @(posedge clock); #1;
    exp_cnt = '0;
    checks++;
    if (ctl !== Z || bus.instr_count !== '0) begin
      failures++;
      $display("FAIL reset_in_wait ctl=%h cnt=%0d exp ctl=%h cnt=0", ctl, bus.instr_count, Z);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (ctl !== F) begin
      failures++;
      $display("FAIL reset_in_wait_fetch ctl=%h exp=%h", ctl, F);
    end
  endtask

  task automatic test_count_wrap();
    logic [CNT_W-1:0] e16, e17;
    e16 = '0;
`ifdef CU_PERF_COUNT_EN
    e17 = 4'd1;
`else
    e17 = 4'd0;
`endif
    bus.opcode = 6'b010000;
    for (int i = 0; i < 48; i++) begin
      @(posedge clock); #1;
    end
    #1;
    checks++;
    if (bus.instr_count !== e16 || ctl !== F) begin
      failures++;
      $display("FAIL count_wrap16 cnt=%0d ctl=%h exp cnt=%0d ctl=%h", bus.instr_count, ctl, e16, F);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
    end
    #1;
    checks++;
    if (bus.instr_count !== e17 || ctl !== F) begin
      failures++;
      $display("FAIL count_wrap17 cnt=%0d ctl=%h exp cnt=%0d ctl=%h", bus.instr_count, ctl, e17, F);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_cnt  = '0;
    test_reset();
    test_opcodes();
    test_input();
    test_output();
    test_halt();
    test_reset_in_wait();
    test_count_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
